// File: rtl/ctrl_seq.sv
// Microcoded control sequencer: steps through T-states and decodes the control word
// from state/step/opcode. Optional single-step debug input enabled by CTRL_SEQ_STEP_EN.
module ctrl_seq #(
  parameter int OPCODE_W = 4,
  parameter int STEPS    = 6,
  parameter int FLAGS_W  = 4,
  parameter int CF_BIT   = 0,
  parameter int ZF_BIT   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pr_mode,
`ifdef CTRL_SEQ_STEP_EN
  input  logic                       step_en,
`endif
  input  logic [OPCODE_W-1:0]        opcode,
  input  logic [FLAGS_W-1:0]         flags,
  output logic [15:0]                ctrl,
  output logic [$clog2(STEPS)-1:0]   step,
  output logic [1:0]                 state
);

  localparam int SW = $clog2(STEPS);
  localparam logic [SW-1:0] T0   = SW'(0);
  localparam logic [SW-1:0] T1   = SW'(1);
  localparam logic [SW-1:0] T2   = SW'(2);
  localparam logic [SW-1:0] T3   = SW'(3);
  localparam logic [SW-1:0] T4   = SW'(4);
  localparam logic [SW-1:0] TMAX = SW'(STEPS-1);

  localparam logic [15:0] C_HALT      = 16'h0001;
  localparam logic [15:0] C_A_IN      = 16'h0002;
  localparam logic [15:0] C_A_OUT     = 16'h0004;
  localparam logic [15:0] C_B_IN      = 16'h0008;
  localparam logic [15:0] C_ALU_OUT   = 16'h0010;
  localparam logic [15:0] C_ALU_SUB   = 16'h0020;
  localparam logic [15:0] C_INSTR_IN  = 16'h0040;
  localparam logic [15:0] C_INSTR_OUT = 16'h0080;
  localparam logic [15:0] C_MAR_IN    = 16'h0100;
  localparam logic [15:0] C_RAM_IN    = 16'h0200;
  localparam logic [15:0] C_RAM_OUT   = 16'h0400;
  localparam logic [15:0] C_PC_INC    = 16'h0800;
  localparam logic [15:0] C_PC_OUT    = 16'h1000;
  localparam logic [15:0] C_PC_JMP    = 16'h2000;
  localparam logic [15:0] C_FLAGS_IN  = 16'h4000;
  localparam logic [15:0] C_OUT_IN    = 16'h8000;

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_HALT = 2'd1, ST_PROG = 2'd2} state_t;

  state_t          r_state;
  logic [SW-1:0]   r_step;
  logic            r_live;
  logic            w_adv;
  logic            w_op_ok;
  logic [3:0]      w_op;
  logic [15:0]     w_dec;
  logic [SW-1:0]   w_last;

`ifdef CTRL_SEQ_STEP_EN
  assign w_adv = step_en;
`else
  assign w_adv = 1'b1;
`endif

  // Wider opcodes only decode when the upper bits are clear; anything else is a NOP.
  generate
    if (OPCODE_W > 4) begin : g_wide_op
      assign w_op_ok = ~|opcode[OPCODE_W-1:4];
    end else begin : g_narrow_op
      assign w_op_ok = 1'b1;
    end
  endgenerate
  assign w_op = opcode[3:0];

  always_comb begin
    w_dec  = '0;
    w_last = T2;
    if (w_op_ok) begin
      case (w_op)
        4'd1, 4'd4: w_last = T3;
        4'd2, 4'd3: w_last = T4;
        default:    w_last = T2;
      endcase
    end
    if (r_state == ST_RUN) begin
      if (r_step == T0)      w_dec = C_PC_OUT | C_MAR_IN;
      else if (r_step == T1) w_dec = C_RAM_OUT | C_INSTR_IN | C_PC_INC;
      else if (w_op_ok) begin
        case (w_op)
          4'd1: begin
            if (r_step == T2)      w_dec = C_INSTR_OUT | C_MAR_IN;
            else if (r_step == T3) w_dec = C_RAM_OUT | C_A_IN;
          end
          4'd2, 4'd3: begin
            if (r_step == T2)      w_dec = C_INSTR_OUT | C_MAR_IN;
            else if (r_step == T3) w_dec = C_RAM_OUT | C_B_IN;
            else if (r_step == T4) w_dec = C_ALU_OUT | C_A_IN | C_FLAGS_IN |
                                           ((w_op == 4'd3) ? C_ALU_SUB : 16'h0000);
          end
          4'd4: begin
            if (r_step == T2)      w_dec = C_INSTR_OUT | C_MAR_IN;
            else if (r_step == T3) w_dec = C_A_OUT | C_RAM_IN;
          end
          4'd5:  if (r_step == T2) w_dec = C_INSTR_OUT | C_A_IN;
          4'd6:  if (r_step == T2) w_dec = C_INSTR_OUT | C_PC_JMP;
          4'd7:  if (r_step == T2 && flags[CF_BIT]) w_dec = C_INSTR_OUT | C_PC_JMP;
          4'd8:  if (r_step == T2 && flags[ZF_BIT]) w_dec = C_INSTR_OUT | C_PC_JMP;
          4'd14: if (r_step == T2) w_dec = C_A_OUT | C_OUT_IN;
          4'd15: if (r_step == T2) w_dec = C_HALT;
          default: ;
        endcase
      end
    end
  end

  // r_live holds off the first decode until one edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
      r_step  <= '0;
      r_live  <= 1'b0;
    end else if (pr_mode) begin
      r_state <= ST_PROG;
      r_step  <= '0;
      r_live  <= 1'b1;
    end else if (!r_live) begin
      r_live  <= 1'b1;
    end else if (w_adv) begin
      case (r_state)
        ST_RUN: begin
          if (w_dec[0]) begin
            r_state <= ST_HALT;
            r_step  <= '0;
          end else if (r_step == w_last || r_step == TMAX) begin
            r_step  <= '0;
          end else begin
            r_step  <= r_step + SW'(1);
          end
        end
        ST_PROG: begin
          r_state <= ST_RUN;
          r_step  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign ctrl  = (r_live && w_adv) ? w_dec : 16'h0000;
  assign step  = r_step;
  assign state = r_state;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed table-driven bench for ctrl_seq plus hand sequences for halt, program
// mode, async reset and (with CTRL_SEQ_STEP_EN) single-step.
module tb_ctrl_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        pr_mode;
`ifdef CTRL_SEQ_STEP_EN
  logic        step_en;
`endif
  logic [3:0]  opcode;
  logic [3:0]  flags;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_seq dut (
    .clk    (clk),
    .rst    (rst),
    .pr_mode(pr_mode),
`ifdef CTRL_SEQ_STEP_EN
    .step_en(step_en),
`endif
    .opcode (opcode),
    .flags  (flags),
    .ctrl   (ctrl),
    .step   (step),
    .state  (state)
  );

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  fl;
    logic [15:0] c;
    logic [2:0]  s;
    logic [1:0]  st;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] op, input logic [3:0] fl,
                     input logic [15:0] c, input logic [2:0] s);
    vec_t v;
    v.op = op; v.fl = fl; v.c = c; v.s = s; v.st = 2'd0;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [15:0] c, input logic [2:0] s,
                     input logic [1:0] st);
    checks++;
    if (ctrl !== c || step !== s || state !== st) begin
      errors++;
      $display("FAIL %s: got ctrl=%h step=%0d state=%0d, expected ctrl=%h step=%0d state=%0d",
               nm, ctrl, step, state, c, s, st);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // LDA
    add(4'd1, 4'd0, 16'h1100, 3'd0); add(4'd1, 4'd0, 16'h0C40, 3'd1);
    add(4'd1, 4'd0, 16'h0180, 3'd2); add(4'd1, 4'd0, 16'h0402, 3'd3);
    // ADD
    add(4'd2, 4'd0, 16'h1100, 3'd0); add(4'd2, 4'd0, 16'h0C40, 3'd1);
    add(4'd2, 4'd0, 16'h0180, 3'd2); add(4'd2, 4'd0, 16'h0408, 3'd3);
    add(4'd2, 4'd0, 16'h4012, 3'd4);
    // SUB
    add(4'd3, 4'd0, 16'h1100, 3'd0); add(4'd3, 4'd0, 16'h0C40, 3'd1);
    add(4'd3, 4'd0, 16'h0180, 3'd2); add(4'd3, 4'd0, 16'h0408, 3'd3);
    add(4'd3, 4'd0, 16'h4032, 3'd4);
    // JC taken, then JC not taken with carry only outside T2
    add(4'd7, 4'd1, 16'h1100, 3'd0); add(4'd7, 4'd1, 16'h0C40, 3'd1);
    add(4'd7, 4'd1, 16'h2080, 3'd2);
    add(4'd7, 4'd1, 16'h1100, 3'd0); add(4'd7, 4'd1, 16'h0C40, 3'd1);
    add(4'd7, 4'd0, 16'h0000, 3'd2);
    // JZ taken on ZF, not taken on CF alone
    add(4'd8, 4'd0, 16'h1100, 3'd0); add(4'd8, 4'd0, 16'h0C40, 3'd1);
    add(4'd8, 4'd2, 16'h2080, 3'd2);
    add(4'd8, 4'd0, 16'h1100, 3'd0); add(4'd8, 4'd0, 16'h0C40, 3'd1);
    add(4'd8, 4'd1, 16'h0000, 3'd2);
    // STA
    add(4'd4, 4'd0, 16'h1100, 3'd0); add(4'd4, 4'd0, 16'h0C40, 3'd1);
    add(4'd4, 4'd0, 16'h0180, 3'd2); add(4'd4, 4'd0, 16'h0204, 3'd3);
    // LDI, JMP, OUT, NOP
    add(4'd5, 4'd0, 16'h1100, 3'd0); add(4'd5, 4'd0, 16'h0C40, 3'd1);
    add(4'd5, 4'd0, 16'h0082, 3'd2);
    add(4'd6, 4'd0, 16'h1100, 3'd0); add(4'd6, 4'd0, 16'h0C40, 3'd1);
    add(4'd6, 4'd0, 16'h2080, 3'd2);
    add(4'd14, 4'd0, 16'h1100, 3'd0); add(4'd14, 4'd0, 16'h0C40, 3'd1);
    add(4'd14, 4'd0, 16'h8004, 3'd2);
    add(4'd9, 4'd0, 16'h1100, 3'd0); add(4'd9, 4'd0, 16'h0C40, 3'd1);
    add(4'd9, 4'd0, 16'h0000, 3'd2);
    // HLT
    add(4'd15, 4'd0, 16'h1100, 3'd0); add(4'd15, 4'd0, 16'h0C40, 3'd1);
    add(4'd15, 4'd0, 16'h0001, 3'd2);

    rst = 1'b0; pr_mode = 1'b0; opcode = 4'd1; flags = 4'd0;
`ifdef CTRL_SEQ_STEP_EN
    step_en = 1'b1;
`endif
    #2 chk("reset", 16'h0000, 3'd0, 2'd0);
    tick();
    chk("reset_held", 16'h0000, 3'd0, 2'd0);
    rst = 1'b1;
    #1 chk("release_pre_edge", 16'h0000, 3'd0, 2'd0);
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      opcode = tbl[i].op;
      flags  = tbl[i].fl;
      #1 chk($sformatf("vec%0d_op%0d", i, tbl[i].op), tbl[i].c, tbl[i].s, tbl[i].st);
      tick();
    end

    opcode = 4'd1;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("halt_%0d", i), 16'h0000, 3'd0, 2'd1);
      tick();
    end
    pr_mode = 1'b1;
    tick();
    chk("halt_to_prog", 16'h0000, 3'd0, 2'd2);
    pr_mode = 1'b0;
    #1 chk("prog_hold", 16'h0000, 3'd0, 2'd2);
    tick();
    opcode = 4'd2;
    #1 chk("prog_to_run", 16'h1100, 3'd0, 2'd0);

    tick(); tick(); tick();
    chk("add_t3", 16'h0408, 3'd3, 2'd0);
    pr_mode = 1'b1;
    #1 chk("add_t3_pr", 16'h0408, 3'd3, 2'd0);
    tick();
    chk("add_abort_prog", 16'h0000, 3'd0, 2'd2);
    pr_mode = 1'b0;
    tick();
    opcode = 4'd1;
    #1 chk("abort_rerun", 16'h1100, 3'd0, 2'd0);

    tick(); tick();
    chk("lda_t2", 16'h0180, 3'd2, 2'd0);
    #2 rst = 1'b0;
    #1 chk("async_reset", 16'h0000, 3'd0, 2'd0);
    tick();
    chk("reset_mid_hold", 16'h0000, 3'd0, 2'd0);
    rst = 1'b1;
    #1 chk("reset_mid_release", 16'h0000, 3'd0, 2'd0);
    tick();
    chk("reset_mid_t0", 16'h1100, 3'd0, 2'd0);

`ifdef CTRL_SEQ_STEP_EN
    tick();
    chk("se_t1", 16'h0C40, 3'd1, 2'd0);
    step_en = 1'b0;
    #1 chk("se_mask", 16'h0000, 3'd1, 2'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("se_hold_%0d", i), 16'h0000, 3'd1, 2'd0);
    end
    step_en = 1'b1;
    #1 chk("se_unmask", 16'h0C40, 3'd1, 2'd0);
    tick();
    step_en = 1'b0;
    #1 chk("se_pulse", 16'h0000, 3'd2, 2'd0);
    pr_mode = 1'b1;
    tick();
    chk("se_pr_mode", 16'h0000, 3'd0, 2'd2);
    pr_mode = 1'b0; step_en = 1'b1;
    tick();
    chk("se_prog_run", 16'h1100, 3'd0, 2'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 Parameter OPCODE_W, default 4, opcode width; supported values are 4 to 8, and only opcode values 0-15 are decoded.
REQ-002 Parameter STEPS, default 6, number of T-states in the step counter; minimum 5.
REQ-003 Parameter FLAGS_W, default 4, width of the flags input.
REQ-004 Parameters CF_BIT, default 0, and ZF_BIT, default 1, give the carry and zero bit positions within flags.
REQ-005 clk  in  1  system clock; all state changes on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 pr_mode  in  1  program mode; 1 suspends execution so the external loader can own the bus.
REQ-008 opcode  in  OPCODE_W  opcode field from the external instruction register.
REQ-009 flags  in  FLAGS_W  latched ALU flags.
REQ-010 ctrl  out  16  control word; bit map: 0 halt, 1 a_in, 2 a_out, 3 b_in, 4 alu_out, 5 alu_sub, 6 instr_in, 7 instr_out, 8 mar_in, 9 ram_in, 10 ram_out, 11 pc_inc, 12 pc_out, 13 pc_jmp, 14 flags_in, 15 out_in.
REQ-011 step  out  clog2(STEPS)  current T-state.
REQ-012 state  out  2  current state: 0 RUN, 1 HALT, 2 PROG.

Function
REQ-013 ctrl SHALL be a combinational decode of the registered state, step and opcode; it SHALL be zero outside RUN.
REQ-014 In RUN, T0 SHALL drive pc_out|mar_in, and T1 SHALL drive ram_out|instr_in|pc_inc, for every opcode.
REQ-015 Per opcode, from T2: 1 LDA = instr_out|mar_in, then ram_out|a_in; 2 ADD = instr_out|mar_in, then ram_out|b_in, then alu_out|a_in|flags_in; 3 SUB = as ADD, with alu_sub also set in the last step; 4 STA = instr_out|mar_in, then a_out|ram_in; 5 LDI = instr_out|a_in; 6 JMP = instr_out|pc_jmp; 14 OUT = a_out|out_in; 15 HLT = halt.
REQ-016 7 JC and 8 JZ SHALL drive instr_out|pc_jmp at T2 only when flags[CF_BIT] (JC) or flags[ZF_BIT] (JZ) is 1; otherwise T2 SHALL drive zero.
REQ-017 All other opcode values SHALL execute as NOP: only T0 and T1 are driven.
REQ-018 The step counter SHALL increment each clock in RUN.
REQ-019 The step counter SHALL return to 0 on the clock following the last non-zero step of the instruction; the earliest return is after T2, and a zero-valued T2 step is still spent.
REQ-020 The step counter SHALL wrap from STEPS-1 to 0 regardless of opcode.
REQ-021 HLT at T2 SHALL move the state to HALT on the next edge, with step 0; HALT SHALL persist until pr_mode=1 or reset.
REQ-022 pr_mode=1 SHALL move any state to PROG on the next edge with step 0, aborting any partial instruction.
REQ-023 While pr_mode=0, PROG SHALL return to RUN at T0.
REQ-024 Flags SHALL be sampled combinationally during T2 only; flag changes in other steps have no effect.

Reset
REQ-025 rst=0 SHALL immediately set state=RUN, step=0 and ctrl=0.
REQ-026 After rst deasserts, the first edge SHALL enter T0 decode: ctrl=pc_out|mar_in once step=0 is sampled in RUN.
REQ-027 Reset mid-instruction SHALL abandon the instruction with no further control pulses.

Configuration
REQ-028 Macro CTRL_SEQ_STEP_EN, when defined, SHALL add input step_en (1 bit) for single-step debug.
REQ-029 With CTRL_SEQ_STEP_EN defined, step and state SHALL advance only on edges where step_en=1, and ctrl SHALL be masked to zero while step_en=0; pr_mode and reset SHALL still act immediately.
REQ-030 Without CTRL_SEQ_STEP_EN, the step_en port SHALL be absent and behaviour SHALL equal step_en tied to 1.

Verification
REQ-031 Reset release, opcode=1 (LDA) -> ctrl=0x1100, then 0x0C40, then 0x0180, then 0x0402; step returns to 0 after T3.
REQ-032 opcode=3 (SUB) -> T4 ctrl=0x4032; the next cycle is step 0 with ctrl=0x1100.
REQ-033 opcode=7 with flags=4'b0001 -> T2 ctrl=0x2080; with flags=4'b0000 -> T2 ctrl=0x0000; both return to T0 after T2.
REQ-034 opcode=15 -> T2 ctrl=0x0001, then state=HALT with ctrl held at 0 for 20 cycles; pr_mode pulse -> PROG; pr_mode=0 -> RUN at T0.
REQ-035 pr_mode=1 asserted at T3 of ADD -> next edge state=PROG, step=0, ctrl=0; rst=0 asserted mid-T2 -> step=0 and ctrl=0 with no clock edge.
REQ-036 With CTRL_SEQ_STEP_EN defined, step_en=0 for 5 cycles at T1 -> step stays 1 and ctrl=0; one step_en pulse -> step=2.
